// File: rtl/telemetry_pkg.sv
// Shared constants, enums and frame payload type for the telemetry UART scheduler.
package telemetry_pkg;

    localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
    localparam logic [7:0]  TAG_PITCH  = 8'h01;
    localparam logic [7:0]  TAG_SAMPLE = 8'h02;
    localparam int unsigned FRAME_LEN  = 5;
    localparam int unsigned IDX_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } sched_state_t;

    typedef enum logic {
        SRC_PITCH  = 1'b0,
        SRC_SAMPLE = 1'b1
    } src_sel_t;

    typedef struct packed {
        logic [7:0] tag;
        logic [7:0] hi;
        logic [7:0] lo;
    } frame_payload_t;

    // Byte at position idx of the framed record; the last byte is the XOR checksum.
    function automatic logic [7:0] frame_byte(frame_payload_t p, logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = p.tag;
            3'd2:    b = p.hi;
            3'd3:    b = p.lo;
            default: b = p.tag ^ p.hi ^ p.lo;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/telemetry_slot.sv
// Single-entry holding slot: newest value wins, overwrites of an unsent value raise drop.
module telemetry_slot #(
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             grant,
    output logic             pending,
    output logic [WIDTH-1:0] value,
    output logic             drop
);

    // A grant coinciding with a load hands off the old value, so no loss is counted.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pending <= 1'b0;
            value   <= '0;
            drop    <= 1'b0;
        end else begin
            drop <= load && pending && !grant;
            if (load) begin
                value   <= data;
                pending <= 1'b1;
            end else if (grant) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/telemetry_uart_scheduler.sv
// Arbitrates pitch results and decimated mic samples onto one UART as 5-byte framed records.
module telemetry_uart_scheduler #(
    parameter int unsigned SAMPLE_DIV   = 256,
    parameter int unsigned GUARD_CYCLES = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [10:0] pitch_in,
    input  logic        pitch_valid_in,
    input  logic [15:0] sample_in,
    input  logic        sample_valid_in,
    input  logic        busy_in,
    output logic [7:0]  data_byte_out,
    output logic        trigger_out,
    output logic        frame_done_out,
    output logic [7:0]  drop_count_out
);
    import telemetry_pkg::*;

    localparam int unsigned DIV_W   = 16;
    localparam int unsigned GUARD_W = 4;

    logic [DIV_W-1:0]   div_cnt;
    logic               sample_load_c;

    logic               pitch_pending, sample_pending;
    logic [10:0]        pitch_value;
    logic [15:0]        sample_value;
    logic               pitch_drop, sample_drop;
    logic               grant_pitch_c, grant_sample_c;
    logic [8:0]         drop_sum_c;

    sched_state_t       state, state_d;
    logic [IDX_W-1:0]   idx, idx_d;
    logic [GUARD_W-1:0] guard_cnt, guard_d;
    frame_payload_t     payload, payload_d;
    src_sel_t           last_grant, last_d;
    logic [7:0]         data_d;
    logic               trig_d, fd_d;

    // Only the strobe seen at count 0 reaches the sample slot.
    assign sample_load_c = sample_valid_in && (div_cnt == '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_cnt <= '0;
        end else if (sample_valid_in) begin
            div_cnt <= (div_cnt == DIV_W'(SAMPLE_DIV - 1)) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    telemetry_slot #(.WIDTH(11)) u_pitch_slot (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load     (pitch_valid_in),
        .data     (pitch_in),
        .grant    (grant_pitch_c),
        .pending  (pitch_pending),
        .value    (pitch_value),
        .drop     (pitch_drop)
    );

    telemetry_slot #(.WIDTH(16)) u_sample_slot (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load     (sample_load_c),
        .data     (sample_in),
        .grant    (grant_sample_c),
        .pending  (sample_pending),
        .value    (sample_value),
        .drop     (sample_drop)
    );

    // Saturating lost-value counter; both slots may drop in the same cycle.
    assign drop_sum_c = 9'(drop_count_out) + 9'(pitch_drop) + 9'(sample_drop);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            drop_count_out <= 8'h00;
        end else if (pitch_drop || sample_drop) begin
            drop_count_out <= drop_sum_c[8] ? 8'hFF : drop_sum_c[7:0];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= ST_IDLE;
            idx            <= '0;
            guard_cnt      <= '0;
            payload        <= '0;
            last_grant     <= SRC_SAMPLE;
            data_byte_out  <= 8'h00;
            trigger_out    <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            guard_cnt      <= guard_d;
            payload        <= payload_d;
            last_grant     <= last_d;
            data_byte_out  <= data_d;
            trigger_out    <= trig_d;
            frame_done_out <= fd_d;
        end
    end

    // Arbitration, frame sequencing and UART handshake.
    always_comb begin
        state_d        = state;
        idx_d          = idx;
        guard_d        = guard_cnt;
        payload_d      = payload;
        last_d         = last_grant;
        data_d         = data_byte_out;
        trig_d         = 1'b0;
        fd_d           = 1'b0;
        grant_pitch_c  = 1'b0;
        grant_sample_c = 1'b0;

        case (state)
            ST_IDLE: begin
                if (pitch_pending && (!sample_pending || last_grant == SRC_SAMPLE)) begin
                    grant_pitch_c = 1'b1;
                    payload_d     = '{tag: TAG_PITCH, hi: {5'b0, pitch_value[10:8]},
                                      lo: pitch_value[7:0]};
                    last_d        = SRC_PITCH;
                    idx_d         = '0;
                    state_d       = ST_SEND;
                end else if (sample_pending) begin
                    grant_sample_c = 1'b1;
                    payload_d      = '{tag: TAG_SAMPLE, hi: sample_value[15:8],
                                       lo: sample_value[7:0]};
                    last_d         = SRC_SAMPLE;
                    idx_d          = '0;
                    state_d        = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!busy_in) begin
                    trig_d  = 1'b1;
                    data_d  = frame_byte(payload, idx);
                    guard_d = '0;
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: begin
                // busy_in lags the trigger, so it is ignored for a fixed window.
                if (guard_cnt == GUARD_W'(GUARD_CYCLES - 1)) begin
                    state_d = ST_WAIT;
                end else begin
                    guard_d = guard_cnt + GUARD_W'(1);
                end
            end
            ST_WAIT: begin
                if (!busy_in) begin
                    if (idx == IDX_W'(FRAME_LEN - 1)) begin
                        fd_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx + IDX_W'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_telemetry_uart_scheduler.sv
// Directed bench for telemetry_uart_scheduler: single-frame vector table plus multi-cycle sequences.
module tb_telemetry_uart_scheduler;

    logic        clk_in;
    logic        rst_n_in;
    logic [10:0] pitch_in;
    logic        pitch_valid_in;
    logic [15:0] sample_in;
    logic        sample_valid_in;
    logic        busy_in;
    logic [7:0]  data_byte_out;
    logic        trigger_out;
    logic        frame_done_out;
    logic [7:0]  drop_count_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] trig_q[$];
    int         trig_cyc[$];
    int         fd_count = 0;

    int busy_len   = 0;
    int busy_cnt   = 0;
    logic force_busy = 1'b0;

    typedef struct {
        logic        is_sample;
        logic [15:0] value;
        int          blen;
        logic [7:0]  tag;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [7:0]  ck;
    } vec_t;

    vec_t vecs[6];

    telemetry_uart_scheduler #(.SAMPLE_DIV(4), .GUARD_CYCLES(2)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .pitch_in        (pitch_in),
        .pitch_valid_in  (pitch_valid_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .busy_in         (busy_in),
        .data_byte_out   (data_byte_out),
        .trigger_out     (trigger_out),
        .frame_done_out  (frame_done_out),
        .drop_count_out  (drop_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // UART model: busy for busy_len cycles after each trigger.
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) busy_cnt <= 0;
        else if (trigger_out && busy_len > 0) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign busy_in = force_busy || (busy_cnt != 0);

    always @(negedge clk_in) begin
        if (rst_n_in && trigger_out) begin
            trig_q.push_back(data_byte_out);
            trig_cyc.push_back(cyc);
        end
        if (rst_n_in && frame_done_out) fd_count <= fd_count + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        rst_n_in        = 1'b0;
        pitch_valid_in  = 1'b0;
        sample_valid_in = 1'b0;
        pitch_in        = '0;
        sample_in       = '0;
        force_busy      = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        tick();
    endtask

    task automatic pulse_pitch(input logic [10:0] v);
        pitch_in       = v;
        pitch_valid_in = 1'b1;
        tick();
        pitch_valid_in = 1'b0;
    endtask

    task automatic pulse_sample(input logic [15:0] v);
        sample_in       = v;
        sample_valid_in = 1'b1;
        tick();
        sample_valid_in = 1'b0;
    endtask

    task automatic wait_fd(input string name, input int n, input int budget);
        for (int i = 0; i < budget && fd_count < n; i++) tick();
        chk({name, "_frames"}, 32'(fd_count), 32'(n));
    endtask

    task automatic check_frame(input string nm, input int base,
                               input logic [7:0] tag, input logic [7:0] hi,
                               input logic [7:0] lo, input logic [7:0] ck);
        logic [7:0] exp[5];
        exp = '{8'hA5, tag, hi, lo, ck};
        for (int i = 0; i < 5; i++) begin
            if (base + i < trig_q.size()) begin
                chk($sformatf("%s_b%0d", nm, i), 32'(trig_q[base + i]), 32'(exp[i]));
            end else begin
                total++;
                bad++;
                $display("FAIL %s_b%0d actual=missing required=%h", nm, i, exp[i]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, fd0, c0, n, rc;

        vecs[0] = '{1'b0, 16'h05A3, 87, 8'h01, 8'h05, 8'hA3, 8'hA7};
        vecs[1] = '{1'b0, 16'h07FF,  0, 8'h01, 8'h07, 8'hFF, 8'hF9};
        vecs[2] = '{1'b0, 16'h0000,  5, 8'h01, 8'h00, 8'h00, 8'h01};
        vecs[3] = '{1'b1, 16'h1234,  0, 8'h02, 8'h12, 8'h34, 8'h24};
        vecs[4] = '{1'b1, 16'hFFFF, 12, 8'h02, 8'hFF, 8'hFF, 8'h02};
        vecs[5] = '{1'b1, 16'h8001,  0, 8'h02, 8'h80, 8'h01, 8'h83};

        apply_reset();
        chk("rst_data",  32'(data_byte_out),  32'h00);
        chk("rst_trig",  32'(trigger_out),    32'h0);
        chk("rst_fd",    32'(frame_done_out), 32'h0);
        chk("rst_drop",  32'(drop_count_out), 32'h00);
        base = trig_q.size();
        repeat (10) tick();
        chk("idle_no_trig", 32'(trig_q.size()), 32'(base));

        // Table of single-frame vectors.
        foreach (vecs[k]) begin
            apply_reset();
            busy_len = vecs[k].blen;
            base = trig_q.size();
            fd0  = fd_count;
            c0   = cyc;
            if (vecs[k].is_sample) pulse_sample(vecs[k].value);
            else pulse_pitch(11'(vecs[k].value));
            wait_fd($sformatf("vec%0d", k), fd0 + 1, 3000);
            repeat (5) tick();
            check_frame($sformatf("vec%0d", k), base, vecs[k].tag, vecs[k].hi,
                        vecs[k].lo, vecs[k].ck);
            chk($sformatf("vec%0d_fd_once", k), 32'(fd_count), 32'(fd0 + 1));
            chk($sformatf("vec%0d_drop", k), 32'(drop_count_out), 32'h0);
            if (trig_cyc.size() > base)
                chk($sformatf("vec%0d_latency", k), 32'(trig_cyc[base] - c0), 32'd3);
            if (vecs[k].blen == 0 && trig_cyc.size() >= base + 5)
                for (int j = 1; j < 5; j++)
                    chk($sformatf("vec%0d_space%0d", k, j),
                        32'(trig_cyc[base + j] - trig_cyc[base + j - 1]), 32'd4);
        end

        // Tie, then a second tie resolved in favour of sample.
        apply_reset();
        busy_len = 0;
        base = trig_q.size();
        fd0  = fd_count;
        pitch_in = 11'h5A3; sample_in = 16'h1234;
        pitch_valid_in = 1'b1; sample_valid_in = 1'b1;
        tick();
        pitch_valid_in = 1'b0; sample_valid_in = 1'b0;
        repeat (6) tick();
        pulse_pitch(11'h0AB);
        wait_fd("tie", fd0 + 3, 500);
        check_frame("tie_p1", base,      8'h01, 8'h05, 8'hA3, 8'hA7);
        check_frame("tie_s",  base + 5,  8'h02, 8'h12, 8'h34, 8'h24);
        check_frame("tie_p2", base + 10, 8'h01, 8'h00, 8'hAB, 8'hAA);
        chk("tie_drop", 32'(drop_count_out), 32'h0);

        // Overwrites during an active frame.
        apply_reset();
        busy_len = 87;
        base = trig_q.size();
        fd0  = fd_count;
        pulse_pitch(11'h100);
        for (int i = 0; i < 100 && trig_q.size() <= base; i++) tick();
        pulse_pitch(11'h111); tick();
        pulse_pitch(11'h222); tick();
        pulse_pitch(11'h333);
        wait_fd("drop", fd0 + 2, 3000);
        chk("drop_count2", 32'(drop_count_out), 32'd2);
        check_frame("drop_f1", base,     8'h01, 8'h01, 8'h00, 8'h00);
        check_frame("drop_f2", base + 5, 8'h01, 8'h03, 8'h33, 8'h31);

        // Decimation by 4 with the UART idle.
        apply_reset();
        busy_len = 0;
        base = trig_q.size();
        fd0  = fd_count;
        for (int i = 0; i < 10; i++) begin
            pulse_sample(16'h1000 + 16'(i));
            repeat (39) tick();
        end
        chk("div_frames", 32'(fd_count), 32'(fd0 + 3));
        chk("div_bytes",  32'(trig_q.size()), 32'(base + 15));
        check_frame("div_s0", base,      8'h02, 8'h10, 8'h00, 8'h12);
        check_frame("div_s4", base + 5,  8'h02, 8'h10, 8'h04, 8'h16);
        check_frame("div_s8", base + 10, 8'h02, 8'h10, 8'h08, 8'h1A);

        // busy held at SEND for 1000 cycles, with enough overwrites to saturate.
        apply_reset();
        busy_len   = 0;
        force_busy = 1'b1;
        base = trig_q.size();
        fd0  = fd_count;
        pulse_pitch(11'h155);
        for (int i = 0; i < 300; i++) begin
            tick();
            pulse_pitch((i == 299) ? 11'h2AA : 11'(i));
        end
        repeat (1000 - 601) tick();
        chk("hold_no_trig", 32'(trig_q.size()), 32'(base));
        chk("drop_sat",     32'(drop_count_out), 32'hFF);
        force_busy = 1'b0;
        rc = cyc;
        for (int i = 0; i < 10 && trig_q.size() <= base; i++) tick();
        if (trig_cyc.size() > base)
            chk("hold_release_lat", 32'(trig_cyc[base] - rc), 32'd1);
        else
            chk("hold_release_trig", 32'(trig_q.size()), 32'(base + 1));
        wait_fd("hold", fd0 + 2, 500);
        check_frame("hold_f1", base,     8'h01, 8'h01, 8'h55, 8'h55);
        check_frame("hold_f2", base + 5, 8'h01, 8'h02, 8'hAA, 8'hA9);

        // Reset asserted while byte 2 is being triggered.
        apply_reset();
        busy_len = 87;
        pulse_pitch(11'h5A3);
        n = 0;
        for (int i = 0; i < 2000 && n < 3; i++) begin
            @(negedge clk_in);
            if (trigger_out) n++;
        end
        chk("rst_mid_reached", 32'(n), 32'd3);
        chk("rst_mid_byte_pre", 32'(data_byte_out), 32'h05);
        #1 rst_n_in = 1'b0;
        #1;
        chk("rst_mid_trig", 32'(trigger_out),    32'h0);
        chk("rst_mid_data", 32'(data_byte_out),  32'h00);
        chk("rst_mid_fd",   32'(frame_done_out), 32'h0);
        chk("rst_mid_drop", 32'(drop_count_out), 32'h00);
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        tick();
        base = trig_q.size();
        fd0  = fd_count;
        pulse_pitch(11'h2C4);
        wait_fd("rst_after", fd0 + 1, 3000);
        check_frame("rst_after", base, 8'h01, 8'h02, 8'hC4, 8'hC7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
